// File: rtl/wired_mdu_mul.sv
// wired_mdu_mul: fully pipelined WIDTH x WIDTH integer multiplier with
// per-stage valid/ready backpressure, bubble collapsing and flush.
// S1 holds the extended operands, S2 holds the product (DSP inference
// point), and S3..S_LATENCY carry the product to give retiming slack.
module wired_mdu_mul #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int WID_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   req_r0_i,
    input  logic [WIDTH-1:0]   req_r1_i,
    input  logic [1:0]         req_op_i,
    input  logic [WID_W-1:0]   req_wid_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   resp_result_o,
    output logic [WID_W-1:0]   resp_wid_o
);

    localparam int PW   = 2 * WIDTH;
    localparam int LAST = LATENCY - 1;

    // Per-stage control and payload; index 0 is S1.
    logic [LATENCY-1:0]  r_vld;
    logic [1:0]          r_op  [LATENCY];
    logic [WID_W-1:0]    r_wid [LATENCY];
    logic signed [WIDTH:0] r_a_p0;
    logic signed [WIDTH:0] r_b_p0;
    logic [PW-1:0]       r_prod [1:LATENCY-1];

    logic [LATENCY-1:0]  w_en;
    logic                w_chain;
    logic                w_a_sx;
    logic                w_b_sx;
    logic signed [PW-1:0] w_a_wide;
    logic signed [PW-1:0] w_b_wide;
    logic signed [PW-1:0] w_prod;

    // MUL returns the low half; every high-half variant returns the upper half.
    function automatic logic [WIDTH-1:0] sel_half(input logic [1:0] op,
                                                  input logic [PW-1:0] prod);
        return (op == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
    endfunction

    // r0 is signed for MUL/MULH/MULHSU, r1 is signed for MUL/MULH only.
    assign w_a_sx = (req_op_i != 2'b11) && req_r0_i[WIDTH-1];
    assign w_b_sx = !req_op_i[1] && req_r1_i[WIDTH-1];

    // Sign-extend to the kept product width; low 2*WIDTH bits of the
    // (WIDTH+1)x(WIDTH+1) signed product are exact under this truncation.
    assign w_a_wide = {{(WIDTH-1){r_a_p0[WIDTH]}}, r_a_p0};
    assign w_b_wide = {{(WIDTH-1){r_b_p0[WIDTH]}}, r_b_p0};
    assign w_prod   = w_a_wide * w_b_wide;

    // Load enables ripple back from ready_i: a stage loads when it is empty or
    // when everything downstream of it can move, which collapses bubbles.
    always_comb begin
        w_en    = '0;
        w_chain = ready_i;
        for (int k = LAST; k >= 0; k--) begin
            w_chain = w_chain || !r_vld[k];
            w_en[k] = w_chain;
        end
    end

    // Valid chain: advance on load enable, cleared entirely by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (flush_i) begin
            r_vld <= '0;
        end else begin
            if (w_en[0]) begin
                r_vld[0] <= valid_i;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (w_en[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    // Payload registers load only when their stage takes a valid op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_p0 <= '0;
            r_b_p0 <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_op[k]  <= '0;
                r_wid[k] <= '0;
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            // S1: capture extended operands
            if (w_en[0] && valid_i) begin
                r_op[0]  <= req_op_i;
                r_wid[0] <= req_wid_i;
                r_a_p0   <= {w_a_sx, req_r0_i};
                r_b_p0   <= {w_b_sx, req_r1_i};
            end
            // S2: product register
            if (w_en[1] && r_vld[0]) begin
                r_op[1]   <= r_op[0];
                r_wid[1]  <= r_wid[0];
                r_prod[1] <= w_prod;
            end
            // S3..S_LATENCY: carry product unchanged
            for (int k = 2; k < LATENCY; k++) begin
                if (w_en[k] && r_vld[k-1]) begin
                    r_op[k]   <= r_op[k-1];
                    r_wid[k]  <= r_wid[k-1];
                    r_prod[k] <= r_prod[k-1];
                end
            end
        end
    end

    assign ready_o       = w_en[0];
    assign valid_o       = r_vld[LAST];
    assign resp_result_o = sel_half(r_op[LAST], r_prod[LAST]);
    assign resp_wid_o    = r_wid[LAST];

endmodule

// File: tb/tb_wired_mdu_mul.sv
// Self-checking bench for wired_mdu_mul: FIFO reference model with
// age-based visibility, per-cycle output compare, directed scenarios and
// a randomized phase.
module tb_wired_mdu_mul;

    localparam int W  = 32;
    localparam int L  = 3;
    localparam int WW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          valid_i;
    logic          ready_i;
    logic [W-1:0]  r0;
    logic [W-1:0]  r1;
    logic [1:0]    op;
    logic [WW-1:0] wid;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  res;
    logic [WW-1:0] rwid;

    wired_mdu_mul #(.WIDTH(W), .LATENCY(L), .WID_W(WW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .req_r0_i     (r0),
        .req_r1_i     (r1),
        .req_op_i     (op),
        .req_wid_i    (wid),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .resp_result_o(res),
        .resp_wid_o   (rwid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic [WW-1:0] wid;
        int            acc;
    } ent_t;

    typedef struct {
        logic [W-1:0]  res;
        logic [WW-1:0] wid;
        int            c;
    } log_t;

    ent_t mq[$];
    log_t rlog[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference product from plain 64-bit arithmetic on the operand values.
    function automatic logic [W-1:0] ref_mul(input logic [1:0] o,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00, 2'b01: p = sa * sb;
            2'b10:        p = sa * ub;
            default:      p = ua * ub;
        endcase
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Head op is visible once LATENCY-1 edges have passed since its accept.
    function automatic bit m_valid();
        return (mq.size() > 0) && ((cyc - mq[0].acc) >= L - 1);
    endfunction

    // Room exists while fewer than LATENCY ops are held, or the head drains.
    function automatic bit m_ready();
        return (mq.size() < L) || (ready_i === 1'b1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            bit v;
            bit rd;
            v  = m_valid();
            rd = m_ready();
            cyc++;
            if (v && ready_i === 1'b1) void'(mq.pop_front());
            if (flush_i === 1'b1) mq.delete();
            else if (valid_i === 1'b1 && rd)
                mq.push_back('{ref_mul(op, r0, r1), wid, cyc});
        end else begin
            cyc++;
        end
    end

    always @(negedge rst_n) mq.delete();

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ready_o", ready_o, m_ready());
        chk("valid_o", valid_o, m_valid());
        if (m_valid()) begin
            chk("resp_result", res, mq[0].res);
            chk("resp_wid", rwid, mq[0].wid);
        end
        if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1)
            rlog.push_back('{res, rwid, cyc});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Hold a request until accepted; returns the number of stalled cycles.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [WW-1:0] w,
                         output int waited);
        bit done;
        done    = 1'b0;
        waited  = 0;
        valid_i = 1'b1;
        op = o; r0 = a; r1 = b; wid = w;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            done   = (ready_o === 1'b1);
            waited = i;
            @(posedge clk);
            #2;
        end
        valid_i = 1'b0;
        chk("issue_accepted", done, 1);
    endtask

    task automatic wait_resp(input string nm, input logic [W-1:0] exp_res,
                             input int exp_lat);
        int n;
        n = 0;
        while (valid_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_result"}, res, exp_res);
    endtask

    task automatic drain();
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 30 && mq.size() != 0; i++) step();
        chk("drain_empty", mq.size(), 0);
        step();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        logic [W-1:0] hold;
        logic [1:0] ops2 [4];
        logic [W-1:0] exp2 [4];
        ops2[0] = 2'b01; ops2[1] = 2'b11; ops2[2] = 2'b10; ops2[3] = 2'b00;
        exp2[0] = 32'h0000_0000; exp2[1] = 32'hFFFF_FFFE;
        exp2[2] = 32'hFFFF_FFFF; exp2[3] = 32'h0000_0001;

        rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op = '0; r0 = '0; r1 = '0; wid = '0;
        #12;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_result", res, 0);
        chk("rst_wid", rwid, 0);
        chk("rst_ready_o", ready_o, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        step();

        // Single MUL with latency check
        issue(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 6'd5, w);
        wait_resp("t1", 32'hFFFF_FFEB, L - 1);
        chk("t1_wid", rwid, 5);
        drain();

        // Four modes back-to-back on all-ones operands
        rlog.delete();
        for (int i = 0; i < 4; i++) issue(ops2[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, WW'(10 + i), w);
        drain();
        chk("t2_count", rlog.size(), 4);
        for (int i = 0; i < 4 && i < rlog.size(); i++) begin
            chk($sformatf("t2_res%0d", i), rlog[i].res, exp2[i]);
            chk($sformatf("t2_cyc%0d", i), rlog[i].c - rlog[0].c, i);
        end

        // Backpressure: fill with ready_i low, then release
        rlog.delete();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, W'(i + 1), 32'd100, WW'(20 + i), w);
            chk($sformatf("t3_wait%0d", i), w, 0);
        end
        valid_i = 1'b1; op = 2'b11; r0 = $urandom; r1 = $urandom; wid = 6'd23;
        #1;
        chk("t3_full_ready", ready_o, 0);
        hold = res;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #3;
            chk("t3_stall_ready", ready_o, 0);
            chk("t3_stall_valid", valid_o, 1);
            chk("t3_stall_hold", res, hold);
        end
        ready_i = 1'b1;
        #1;
        chk("t3_ready_rise", ready_o, 1);
        @(posedge clk); #2;
        valid_i = 1'b0;
        issue(2'b10, pick(), pick(), 6'd24, w);
        drain();
        chk("t3_count", rlog.size(), 5);
        for (int i = 0; i < 5 && i < rlog.size(); i++)
            chk($sformatf("t3_order%0d", i), rlog[i].wid, 20 + i);

        // Bubble collapse
        rlog.delete();
        ready_i = 1'b0;
        issue(2'b00, 32'd3, 32'd5, 6'd1, w);
        step();
        step();
        issue(2'b11, 32'h8000_0000, 32'd4, 6'd2, w);
        step();
        #1;
        chk("t4_head_valid", valid_o, 1);
        chk("t4_head_res", res, 32'd15);
        chk("t4_bubble_ready", ready_o, 1);
        ready_i = 1'b1;
        drain();
        chk("t4_count", rlog.size(), 2);
        if (rlog.size() == 2) begin
            chk("t4_b_res", rlog[1].res, 32'd2);
            chk("t4_consecutive", rlog[1].c - rlog[0].c, 1);
        end

        // Flush with ops in flight and a request in the flush cycle
        rlog.delete();
        for (int i = 0; i < 3; i++) issue(2'b01, pick(), pick(), WW'(30 + i), w);
        valid_i = 1'b1; flush_i = 1'b1; op = 2'b00; r0 = 32'd9; r1 = 32'd9; wid = 6'd33;
        step();
        valid_i = 1'b0; flush_i = 1'b0;
        chk("t5_after_flush", valid_o, 0);
        issue(2'b00, 32'd6, 32'd7, 6'd34, w);
        wait_resp("t5", 32'd42, L - 1);
        drain();
        chk("t5_count", rlog.size(), 2);
        if (rlog.size() == 2) begin
            chk("t5_first", rlog[0].wid, 30);
            chk("t5_second", rlog[1].wid, 34);
        end

        // Asynchronous reset mid-burst
        issue(2'b00, 32'd11, 32'd13, 6'd40, w);
        issue(2'b00, 32'd17, 32'd19, 6'd41, w);
        valid_i = 1'b1; op = 2'b00; r0 = 32'd23; r1 = 32'd29; wid = 6'd42;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        rlog.delete();
        chk("t6_valid_o", valid_o, 0);
        chk("t6_result", res, 0);
        chk("t6_wid", rwid, 0);
        chk("t6_ready_o", ready_o, 1);
        valid_i = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("t6_no_stale", rlog.size(), 0);

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 39) == 0);
            op  = 2'($urandom_range(0, 3));
            r0  = pick();
            r1  = pick();
            wid = WW'($urandom);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
